// File: rtl/ling_pkg.sv
// Shared constants and helpers for the pipelined Ling adder.
package ling_pkg;

    localparam int unsigned LING_GROUP = 4;

    // Per-stage control bits carried alongside the partial sum and pending operands.
    typedef struct packed {
        logic valid;
        logic carry;
        logic c_msb;
    } ling_ctl_t;

    function automatic logic ling_seg_ok(input int unsigned seg);
        return (seg != 0) && ((seg % LING_GROUP) == 0);
    endfunction

endpackage

// File: rtl/ling_adder_seg.sv
// Combinational SEG-bit Ling adder segment: group-level pseudo-carry lookahead,
// bit-level pseudo-carry inside each 4-bit group.
module ling_adder_seg
    import ling_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    localparam int unsigned NGRP = SEG / LING_GROUP;

    logic [SEG-1:0] g, t, p;
    logic [SEG:0]   t_ext;
    logic [SEG:0]   h;
    logic [NGRP:0]  hg;
    logic           hgen, htr;

    assign g     = a & b;
    assign t     = a | b;
    assign p     = a ^ b;
    // t_ext[i] is the transmit of bit i-1; the segment's carry-in acts as h[0] with t_ext[0]=1.
    assign t_ext = {t, 1'b1};

    always_comb begin
        h     = '0;
        hg    = '0;
        hgen  = 1'b0;
        htr   = 1'b0;
        hg[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            hgen = g[j*LING_GROUP+3]
                 | (t_ext[j*LING_GROUP+3] & g[j*LING_GROUP+2])
                 | ((&t_ext[j*LING_GROUP+2 +: 2]) & g[j*LING_GROUP+1])
                 | ((&t_ext[j*LING_GROUP+1 +: 3]) & g[j*LING_GROUP]);
            htr       = &t_ext[j*LING_GROUP +: 4];
            hg[j+1]   = hgen | (htr & hg[j]);
            h[j*LING_GROUP] = hg[j];
            for (int i = 0; i < 3; i++) begin
                h[j*LING_GROUP+i+1] = g[j*LING_GROUP+i]
                                    | (t_ext[j*LING_GROUP+i] & h[j*LING_GROUP+i]);
            end
        end
        h[SEG] = hg[NGRP];
    end

    // Real carry into bit i is t_{i-1} & h_i.
    assign sum   = p ^ (t_ext[SEG-1:0] & h[SEG-1:0]);
    assign cout  = t_ext[SEG] & h[SEG];
    assign c_msb = t_ext[SEG-1] & h[SEG-1];

endmodule

// File: rtl/ling_adder_pipe.sv
// Pipelined WIDTH-bit add/subtract built from STAGES carry-registered Ling segments,
// with a valid/ready stream interface and a single global advance enable.
module ling_adder_pipe
    import ling_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG = WIDTH / STAGES;

    typedef struct packed {
        ling_ctl_t        ctl;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
    } stage_t;

    if (!ling_seg_ok(SEG) || (WIDTH != STAGES * SEG)) begin : g_param_check
        $error("ling_adder_pipe: WIDTH must equal STAGES*SEG with SEG a multiple of 4");
    end

    logic   adv;
    stage_t entry;
    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Bubbles enter as all-zero records so idle output data stays at 0.
    always_comb begin
        entry = '0;
        if (in_valid) begin
            entry.ctl.valid = 1'b1;
            entry.ctl.carry = cin ^ sub;
            entry.pa        = a;
            entry.pb        = sub ? ~b : b;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         prev, nxt;
        logic [SEG-1:0] seg_sum;
        logic           seg_cout, seg_cmsb;

        if (k == 0) begin : g_first
            assign prev = entry;
        end else begin : g_next
            assign prev = stage_q[k-1];
        end

        ling_adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (prev.pa[k*SEG +: SEG]),
            .b     (prev.pb[k*SEG +: SEG]),
            .cin   (prev.ctl.carry),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        // Lower sum segments ride along unchanged; consumed operand bits are cleared.
        always_comb begin
            nxt                     = prev;
            nxt.psum[k*SEG +: SEG]  = seg_sum;
            nxt.pa[k*SEG +: SEG]    = '0;
            nxt.pb[k*SEG +: SEG]    = '0;
            nxt.ctl.carry           = seg_cout;
            nxt.ctl.c_msb           = seg_cmsb;
        end

        assign stage_d[k] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].ctl.valid;
    assign sum       = stage_q[STAGES-1].psum;
    assign cout      = stage_q[STAGES-1].ctl.carry;
    assign ovf       = stage_q[STAGES-1].ctl.carry ^ stage_q[STAGES-1].ctl.c_msb;

endmodule

// File: tb/tb_ling_adder_pipe.sv
// Self-checking bench for ling_adder_pipe: directed cases, backpressure, mid-run
// reset and a randomized stream scored against an arithmetic reference model.
module tb_ling_adder_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    always #5 clk = ~clk;

    ling_adder_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain (WIDTH+1)-bit arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] ye;
        exp_t             r;
        ye   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, ci ^ sb};
        r.s  = full[WIDTH-1:0];
        r.c  = full[WIDTH];
        r.o  = (x[WIDTH-1] == ye[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat with out_ready high; returns cycles from accept to out_valid.
    task automatic send_beat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic ci, input logic sb, output int lat);
        int w;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = x; b = y; cin = ci; sub = sb;
        w = 0;
        #2;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #3;
            w++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [5];
        logic [WIDTH-1:0] tb [5];
        logic             ts [5];
        logic [WIDTH-1:0] es [5];
        logic             ec [5];
        logic             eo [5];
        int               lat;
        ta = '{32'h001F001F, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h80000000};
        tb = '{32'h000C001F, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001};
        ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        es = '{32'h002B003E, 32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send_beat(ta[i], tb[i], 1'b0, ts[i], lat);
            checks++; if (lat != STAGES) begin errors++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, STAGES); end
            checks++; if (sum !== es[i]) begin errors++; $display("FAIL directed%0d_sum: got %h want %h", i, sum, es[i]); end
            checks++; if (cout !== ec[i]) begin errors++; $display("FAIL directed%0d_cout: got %b want %b", i, cout, ec[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL directed%0d_ovf: got %b want %b", i, ovf, eo[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int               nxt = 1;
        int               got = 0;
        int               extra = 0;
        logic             hold = 1'b0;
        logic [WIDTH-1:0] held_s = '0;
        logic             held_c = 1'b0;
        logic             held_o = 1'b0;
        cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid  = (nxt <= 6);
            a         = WIDTH'(nxt);
            b         = WIDTH'(nxt);
            out_ready = !(c >= 3 && c < 6);
            #2;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++; $display("FAIL b2b_in_ready: got %b want %b (cycle %0d)", in_ready, !out_valid || out_ready, c);
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held_s || cout !== held_c || ovf !== held_o) begin
                    errors++; $display("FAIL b2b_stall_hold: got v=%b sum=%h want v=1 sum=%h", out_valid, sum, held_s);
                end
            end
            hold   = out_valid && !out_ready;
            held_s = sum; held_c = cout; held_o = ovf;
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (sum !== WIDTH'(2 * got)) begin
                    errors++; $display("FAIL b2b_result%0d: got %0d want %0d", got, sum, 2 * got);
                end
            end
            if (in_valid && in_ready) nxt++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (out_valid) extra++;
            tick();
        end
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d results want 6", got); end
        checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate: got %0d extra results want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = WIDTH'(10 + i); b = WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if ({sum, cout, ovf} !== '0) begin errors++; $display("FAIL rstmid_outputs: got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_flushed: got %0d stale results want 0", seen); end
        send_beat(WIDTH'(3), WIDTH'(4), 1'b0, 1'b0, lat);
        checks++; if (lat != STAGES) begin errors++; $display("FAIL rstmid_latency: got %0d want %0d", lat, STAGES); end
        checks++; if (sum !== WIDTH'(7)) begin errors++; $display("FAIL rstmid_sum: got %0d want 7", sum); end
        tick();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = ($urandom_range(0, 3) == 0) ? ~a : $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL random_extra: got unexpected result sum=%h want none", sum);
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
                        errors++; $display("FAIL random_result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b", sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            #2;
            if (out_valid) begin
                checks++;
                e = q.pop_front();
                if ({sum, cout, ovf} !== {e.s, e.c, e.o}) begin
                    errors++; $display("FAIL random_drain: got sum=%h c=%b o=%b want sum=%h c=%b o=%b", sum, cout, ovf, e.s, e.c, e.o);
                end
            end
            tick();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL random_lost: got %0d results missing want 0", q.size()); end
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
